wakeup_gen: RTL and testbench
=============================

Name: wakeup_gen

Overview:
- Initiator side of the wake_up / WU_valid / WU_serviced handshake.
- Periodically emits a stretched wake_up pulse toward the trigger receiver, then waits for WU_valid.
- After a service delay it asserts WU_serviced until WU_valid drops.
- Keeps sent, serviced, missed and overrun statistics for the signal-generator control path.

Parameters:
- PERIOD, 10000000, clki cycles between wake_up launches (100 MHz -> 10 Hz); legal range 16..2^24-1.
- PULSE_W, 4, wake_up high time in cycles; must be >= 3 so the receiver's 3-stage edge detector sees it.
- SVC_DELAY, 100, cycles WU_valid must be seen before WU_serviced is raised.
- VALID_TO, 64, max cycles to wait for WU_valid after the pulse ends.
- ACK_TO, 64, max cycles WU_serviced is held waiting for WU_valid to fall.

Ports:
- clki  in  1  system clock, 100 MHz
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  level; 1 = periodic launches run
- WU_valid  in  1  receiver's pending flag, asynchronous to the pulse, synchronised internally
- wake_up  out  1  registered trigger pulse
- WU_serviced  out  1  registered service acknowledge
- busy  out  1  1 whenever the FSM is not in IDLE
- sent_count  out  20  launches issued, wraps at 2^20
- serviced_count  out  20  completed handshakes, wraps at 2^20
- miss_count  out  16  failed handshakes, saturates at 16'hFFFF
- overrun_count  out  16  period expiries while busy, saturates

Behaviour:
- Reset: asynchronous, rst_n low clears every flop.
  - All outputs 0, FSM in IDLE, period counter 0, synchroniser flops 0.
  - Release is synchronous to clki; the first launch occurs no earlier than PERIOD cycles after release.
- WU_valid passes through a 2-flop synchroniser; all decisions use the synchronised value (vs), 2-cycle latency.
- Period counter:
  - Increments while enable=1.
  - At PERIOD-1 it reloads 0 and raises tick for 1 cycle.
  - enable=0 holds the counter at 0.
- FSM (registered outputs; one state change per cycle):
  - IDLE: on tick -> PULSE, sent_count+1.
  - PULSE: wake_up=1 for exactly PULSE_W cycles -> WAIT_V.
  - WAIT_V:
    - vs=1 -> SERVICE.
    - VALID_TO cycles without vs -> IDLE, miss_count+1.
  - SERVICE: count SVC_DELAY cycles with vs=1.
    - On completion -> ACK.
    - vs falls before completion (receiver timed out) -> IDLE, miss_count+1.
  - ACK: WU_serviced=1.
    - vs=0 -> IDLE, serviced_count+1, WU_serviced low in the next cycle.
    - ACK_TO expires with vs still 1 -> IDLE, miss_count+1.
- A tick arriving in any non-IDLE state is not queued; overrun_count+1 and the launch is skipped.
- enable falling mid-handshake: the current handshake completes normally; no further launches.
- Same-cycle events:
  - vs falls on the same cycle SVC_DELAY completes -> treated as a miss.
  - Timeout on the same cycle vs rises in WAIT_V -> vs wins.
- A wake_up pulse never overlaps WU_serviced, and each is high only in its own state.

Optional Feature:
- Macro WAKEUP_SWTRIG_EN.
- Defined:
  - Adds input sw_trig (1 bit, synchronous single-cycle pulse).
  - sw_trig in IDLE launches exactly like tick, and the period counter reloads 0.
  - sw_trig when not IDLE counts as an overrun.
  - If sw_trig and tick coincide, only one launch occurs.
- Undefined: port absent; launches come from the period counter only.

Decomposition:
- Package wakeup_pkg:
  - FSM state encoding (IDLE, PULSE, WAIT_V, SERVICE, ACK).
  - Counter widths 20/16.
  - Default parameter constants.
- One sub-module wu_sync: generic 2-flop synchroniser with async active-low reset, used for WU_valid.

Test Plan:
(All scenarios use PERIOD=100, PULSE_W=4, SVC_DELAY=10, VALID_TO=50, ACK_TO=50.)
1. Reset, enable=1, receiver model raises WU_valid 5 cycles after wake_up rise and drops it 3 cycles after WU_serviced rise -> wake_up high 4 cycles at cycle 100; WU_serviced rises 10 cycles after vs; sent_count=1 and serviced_count=1 after the first period.
2. WU_valid never asserted -> after 50 cycles in WAIT_V return to IDLE; miss_count=1, WU_serviced never high.
3. WU_valid drops 5 cycles into SERVICE -> IDLE, miss_count+1, no WU_serviced pulse.
4. Receiver holds WU_valid for 200 cycles -> WU_serviced held 50 cycles, then miss_count+1; next tick lands while busy -> overrun_count=1, sent_count unchanged.
5. rst_n asserted low during ACK -> wake_up, WU_serviced, busy and all counters are 0 immediately, asynchronously; after release, the next launch occurs 100 cycles later.
6. With WAKEUP_SWTRIG_EN defined, sw_trig pulse at cycle 30 -> wake_up high at cycle 31 for 4 cycles; next periodic launch 100 cycles after sw_trig; sw_trig issued while busy -> overrun_count+1.

Source files
------------

// File: rtl/wakeup_pkg.sv
// Shared types and constants for the wake_up / WU_valid / WU_serviced initiator.
// Holds the FSM encoding, statistics counter widths and default timing constants.
package wakeup_pkg;

    localparam int SENT_W   = 20;
    localparam int MISS_W   = 16;
    localparam int PERIOD_W = 24;

    localparam int DEF_PERIOD    = 10_000_000;
    localparam int DEF_PULSE_W   = 4;
    localparam int DEF_SVC_DELAY = 100;
    localparam int DEF_VALID_TO  = 64;
    localparam int DEF_ACK_TO    = 64;

    typedef enum logic [2:0] {
        IDLE,
        PULSE,
        WAIT_V,
        SERVICE,
        ACK
    } wu_state_e;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [MISS_W-1:0] sat_inc(input logic [MISS_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/wu_sync.sv
// Generic two-flop synchroniser for asynchronous level inputs.
// Output follows the input with two clki cycles of latency.
module wu_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clki,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // NOTE: non-blocking assignments let both stages sample the pre-edge values, forming a true 2-stage shift.
    always_ff @(posedge clki or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/wakeup_gen.sv
// Periodic wake_up initiator with WU_valid/WU_serviced handshake and statistics.
// Define WAKEUP_SWTRIG_EN to add the sw_trig software launch input.
module wakeup_gen
    import wakeup_pkg::*;
#(
    parameter int PERIOD    = DEF_PERIOD,     // 16 .. 2^24-1
    parameter int PULSE_W   = DEF_PULSE_W,    // >= 3
    parameter int SVC_DELAY = DEF_SVC_DELAY,  // >= 2
    parameter int VALID_TO  = DEF_VALID_TO,
    parameter int ACK_TO    = DEF_ACK_TO
) (
    input  logic              clki,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              WU_valid,
`ifdef WAKEUP_SWTRIG_EN
    input  logic              sw_trig,
`endif
    output logic              wake_up,
    output logic              WU_serviced,
    output logic              busy,
    output logic [SENT_W-1:0] sent_count,
    output logic [SENT_W-1:0] serviced_count,
    output logic [MISS_W-1:0] miss_count,
    output logic [MISS_W-1:0] overrun_count
);

    localparam int TIMER_MAX = max_of(max_of(PULSE_W, SVC_DELAY), max_of(VALID_TO, ACK_TO));
    localparam int TIMER_W   = $clog2(TIMER_MAX + 1);

    localparam logic [TIMER_W-1:0]  PULSE_LAST = TIMER_W'(PULSE_W - 1);
    localparam logic [TIMER_W-1:0]  VALID_LAST = TIMER_W'(VALID_TO - 1);
    localparam logic [TIMER_W-1:0]  SVC_LAST   = TIMER_W'(SVC_DELAY - 1);
    localparam logic [TIMER_W-1:0]  ACK_LAST   = TIMER_W'(ACK_TO - 1);
    localparam logic [PERIOD_W-1:0] TICK_AT    = PERIOD_W'(PERIOD - 1);

    logic                vs;
    logic [PERIOD_W-1:0] period_cnt;
    logic                tick;
    logic                launch_req;
    logic                sw_reload;
    wu_state_e           state, state_nxt;
    logic [TIMER_W-1:0]  timer, timer_nxt;
    logic                sent_inc, srv_inc, miss_inc, ovr_inc;

    wu_sync #(.WIDTH(1)) u_sync (
        .clki  (clki),
        .rst_n (rst_n),
        .d     (WU_valid),
        .q     (vs)
    );

    assign tick = enable && (period_cnt == TICK_AT);

`ifdef WAKEUP_SWTRIG_EN
    assign launch_req = tick || sw_trig;
    assign sw_reload  = sw_trig && (state == IDLE);
`else
    assign launch_req = tick;
    assign sw_reload  = 1'b0;
`endif

    always_ff @(posedge clki or negedge rst_n) begin
        if (!rst_n) begin
            period_cnt <= '0;
        end else if (!enable || tick || sw_reload) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + 1'b1;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        sent_inc  = 1'b0;
        srv_inc   = 1'b0;
        miss_inc  = 1'b0;
        ovr_inc   = launch_req && (state != IDLE);

        unique case (state)
            IDLE: begin
                if (launch_req) begin
                    state_nxt = PULSE;
                    timer_nxt = '0;
                    sent_inc  = 1'b1;
                end
            end
            PULSE: begin
                if (timer == PULSE_LAST) begin
                    state_nxt = WAIT_V;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            WAIT_V: begin
                // The detection cycle already counts as the first cycle vs was seen.
                if (vs) begin
                    state_nxt = SERVICE;
                    timer_nxt = TIMER_W'(1);
                end else if (timer == VALID_LAST) begin
                    state_nxt = IDLE;
                    miss_inc  = 1'b1;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            SERVICE: begin
                if (!vs) begin
                    state_nxt = IDLE;
                    miss_inc  = 1'b1;
                end else if (timer == SVC_LAST) begin
                    state_nxt = ACK;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            ACK: begin
                if (!vs) begin
                    state_nxt = IDLE;
                    srv_inc   = 1'b1;
                end else if (timer == ACK_LAST) begin
                    state_nxt = IDLE;
                    miss_inc  = 1'b1;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the FSM.
    always_ff @(posedge clki or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            timer          <= '0;
            wake_up        <= 1'b0;
            WU_serviced    <= 1'b0;
            busy           <= 1'b0;
            sent_count     <= '0;
            serviced_count <= '0;
            miss_count     <= '0;
            overrun_count  <= '0;
        end else begin
            state       <= state_nxt;
            timer       <= timer_nxt;
            wake_up     <= (state_nxt == PULSE);
            WU_serviced <= (state_nxt == ACK);
            busy        <= (state_nxt != IDLE);
            if (sent_inc) sent_count <= sent_count + 1'b1;
            if (srv_inc)  serviced_count <= serviced_count + 1'b1;
            if (miss_inc) miss_count <= sat_inc(miss_count);
            if (ovr_inc)  overrun_count <= sat_inc(overrun_count);
        end
    end

endmodule

// File: tb/tb_wakeup_gen.sv
// Self-checking bench for wakeup_gen: table of receiver behaviours with a scoreboard,
// plus hand sequences for asynchronous reset, enable drop and (WAKEUP_SWTRIG_EN) sw_trig.
module tb_wakeup_gen;

    logic        clki = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        WU_valid;
`ifdef WAKEUP_SWTRIG_EN
    logic        sw_trig;
`endif
    logic        wake_up;
    logic        WU_serviced;
    logic        busy;
    logic [19:0] sent_count;
    logic [19:0] serviced_count;
    logic [15:0] miss_count;
    logic [15:0] overrun_count;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    always #5 clki = ~clki;
    always @(posedge clki) cyc <= cyc + 1;

    wakeup_gen #(
        .PERIOD    (100),
        .PULSE_W   (4),
        .SVC_DELAY (10),
        .VALID_TO  (50),
        .ACK_TO    (50)
    ) dut (
        .clki           (clki),
        .rst_n          (rst_n),
        .enable         (enable),
        .WU_valid       (WU_valid),
`ifdef WAKEUP_SWTRIG_EN
        .sw_trig        (sw_trig),
`endif
        .wake_up        (wake_up),
        .WU_serviced    (WU_serviced),
        .busy           (busy),
        .sent_count     (sent_count),
        .serviced_count (serviced_count),
        .miss_count     (miss_count),
        .overrun_count  (overrun_count)
    );

    typedef enum int {RX_NONE, RX_NORMAL, RX_TIMED} rx_mode_e;

    // Receiver behaviour plus expected timing (k = cycles after wake_up rise).
    typedef struct packed {
        rx_mode_e mode;
        int vdly;
        int hold;
        int gap;
        int wake_w;
        int svc_rise;
        int svc_w;
        int idle_k;
        int d_srv;
        int d_miss;
        int d_ovr;
    } vec_t;

    typedef struct packed {
        int idx;
        int gap;
        int wake_w;
        int svc_rise;
        int svc_w;
        int idle_k;
        int sent;
        int srv;
        int miss;
        int ovr;
    } exp_t;

    typedef struct packed {
        int wake_w;
        int svc_rise;
        int svc_w;
        int idle_k;
        int overlap;
    } obs_t;

    localparam int NV = 9;
    vec_t  vecs[NV];
    string names[NV];
    exp_t  sb[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_wake(input string name, output int t);
        int n = 0;
        while (!wake_up && n < 400) begin
            @(negedge clki);
            n++;
        end
        check({name, ".wake_seen"}, int'(wake_up), 1);
        t = cyc;
    endtask

    // Plays the receiver from the wake_up rise until the handshake is over.
    task automatic run_hs(input rx_mode_e mode, input int vdly, input int hold, output obs_t o);
        o = '{default: 0};
        o.svc_rise = -1;
        o.idle_k   = -1;
        for (int k = 0; k < 400; k++) begin
            if (wake_up) o.wake_w++;
            if (WU_serviced) begin
                if (o.svc_rise < 0) o.svc_rise = k;
                o.svc_w++;
            end
            if (wake_up && WU_serviced) o.overlap = 1;
            if (!busy && o.idle_k < 0) o.idle_k = k;
            case (mode)
                RX_NONE:   WU_valid = 1'b0;
                RX_NORMAL: WU_valid = (k >= vdly) && !(o.svc_rise >= 0 && k >= o.svc_rise + 3);
                default:   WU_valid = (k >= vdly) && (k < vdly + hold);
            endcase
            if (o.idle_k >= 0 && (mode != RX_TIMED || k >= vdly + hold)) break;
            @(negedge clki);
        end
        WU_valid = 1'b0;
    endtask

    task automatic check_counts(input string name, input int s, input int v, input int m, input int r);
        check({name, ".sent"}, int'(sent_count), s);
        check({name, ".serviced"}, int'(serviced_count), v);
        check({name, ".miss"}, int'(miss_count), m);
        check({name, ".overrun"}, int'(overrun_count), r);
    endtask

    initial begin
        int   t, prev, rel, n_wake, seen;
        int   e_sent, e_srv, e_miss, e_ovr;
        exp_t e;
        obs_t o;

        names[0] = "normal";    vecs[0] = '{RX_NORMAL,  5,   0, 100, 4, 17,  6,  23, 1, 0, 0};
        names[1] = "no_valid";  vecs[1] = '{RX_NONE,    0,   0, 100, 4, -1,  0,  54, 0, 1, 0};
        names[2] = "drop_svc";  vecs[2] = '{RX_TIMED,   5,   6, 100, 4, -1,  0,  14, 0, 1, 0};
        names[3] = "ack_to";    vecs[3] = '{RX_TIMED,   5,  70, 100, 4, 17, 50,  67, 0, 1, 0};
        names[4] = "overrun";   vecs[4] = '{RX_TIMED,  45, 120, 100, 4, 57, 50, 107, 0, 1, 1};
        names[5] = "vs_wins";   vecs[5] = '{RX_NORMAL, 51,   0, 200, 4, 63,  6,  69, 1, 0, 0};
        names[6] = "vs_late";   vecs[6] = '{RX_TIMED,  52,  10, 100, 4, -1,  0,  54, 0, 1, 0};
        names[7] = "svc_miss";  vecs[7] = '{RX_TIMED,   5,   9, 100, 4, -1,  0,  17, 0, 1, 0};
        names[8] = "svc_ok";    vecs[8] = '{RX_TIMED,   5,  10, 100, 4, 17,  1,  18, 1, 0, 0};

        rst_n    = 1'b0;
        enable   = 1'b1;
        WU_valid = 1'b0;
`ifdef WAKEUP_SWTRIG_EN
        sw_trig  = 1'b0;
`endif
        repeat (3) @(negedge clki);
        check("reset.wake_up", int'(wake_up), 0);
        check("reset.WU_serviced", int'(WU_serviced), 0);
        check("reset.busy", int'(busy), 0);
        check_counts("reset", 0, 0, 0, 0);

        rst_n = 1'b1;
        rel   = cyc;
        prev  = rel;
        e_sent = 0; e_srv = 0; e_miss = 0; e_ovr = 0;

        for (int i = 0; i < NV; i++) begin
            e_sent += 1;
            e_srv  += vecs[i].d_srv;
            e_miss += vecs[i].d_miss;
            e_ovr  += vecs[i].d_ovr;
            sb.push_back('{i, vecs[i].gap, vecs[i].wake_w, vecs[i].svc_rise, vecs[i].svc_w,
                           vecs[i].idle_k, e_sent, e_srv, e_miss, e_ovr});
            wait_wake(names[i], t);
            run_hs(vecs[i].mode, vecs[i].vdly, vecs[i].hold, o);
            e = sb.pop_front();
            check({names[e.idx], ".gap"}, t - prev, e.gap);
            check({names[e.idx], ".wake_w"}, o.wake_w, e.wake_w);
            check({names[e.idx], ".svc_rise"}, o.svc_rise, e.svc_rise);
            check({names[e.idx], ".svc_w"}, o.svc_w, e.svc_w);
            check({names[e.idx], ".idle_k"}, o.idle_k, e.idle_k);
            check({names[e.idx], ".overlap"}, o.overlap, 0);
            check_counts(names[e.idx], e.sent, e.srv, e.miss, e.ovr);
            prev = t;
        end

        // Asynchronous reset while WU_serviced is high.
        wait_wake("rst_ack", t);
        seen = 0;
        for (int k = 0; k < 100 && !seen; k++) begin
            WU_valid = (k >= 5);
            if (WU_serviced) seen = 1;
            else @(negedge clki);
        end
        check("rst_ack.reached_ack", seen, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_ack.wake_up", int'(wake_up), 0);
        check("rst_ack.WU_serviced", int'(WU_serviced), 0);
        check("rst_ack.busy", int'(busy), 0);
        check_counts("rst_ack", 0, 0, 0, 0);
        WU_valid = 1'b0;
        @(negedge clki);
        repeat (2) @(negedge clki);
        rst_n = 1'b1;
        rel   = cyc;

        // First launch after release, then enable drops mid-handshake.
        wait_wake("post_rst", t);
        check("post_rst.gap", t - rel, 100);
        enable = 1'b0;
        run_hs(RX_NORMAL, 5, 0, o);
        check("en_drop.svc_rise", o.svc_rise, 17);
        check("en_drop.idle_k", o.idle_k, 23);
        check_counts("en_drop", 1, 1, 0, 0);
        n_wake = 0;
        repeat (250) begin
            @(negedge clki);
            if (wake_up) n_wake++;
        end
        check("en_off.wake_cycles", n_wake, 0);
        check("en_off.sent", int'(sent_count), 1);

`ifdef WAKEUP_SWTRIG_EN
        enable = 1'b1;
        rel    = cyc;
        repeat (29) @(negedge clki);
        sw_trig = 1'b1;
        @(negedge clki);
        sw_trig = 1'b0;
        check("sw.wake_up", int'(wake_up), 1);
        check("sw.launch_cyc", cyc - rel, 30);
        prev = cyc;
        repeat (10) @(negedge clki);
        sw_trig = 1'b1;
        @(negedge clki);
        sw_trig = 1'b0;
        check("sw_busy.overrun", int'(overrun_count), 1);
        wait_wake("sw_next", t);
        check("sw_next.gap", t - prev, 100);
        check_counts("sw_next", 3, 1, 1, 1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
